alu_serial_seq: RTL and testbench
=================================

Name: alu_serial_seq

Overview:
- Bit-serial ALU sequencer for the 16-bit CPU. It performs one WIDTH-bit operation by driving a single external ALU_1b slice over WIDTH consecutive cycles, one bit per cycle.
- It carries the ripple carry in a register between bits and assembles the result in a shift register.
- It adds a fix-up cycle for SLT and reports DONE/flags to the control unit through a START/BUSY/DONE handshake.

Parameters:
- WIDTH, 16, operand/result width; bit counter is clog2(WIDTH) bits.

Ports:
- CLK  input  1  system clock, rising edge.
- RESETn  input  1  asynchronous, active-low reset.
- START  input  1  request; sampled only in IDLE.
- ALUOP  input  3  0 AND, 1 OR, 2 XOR, 3 ADD, 4 SUB, 5 SLT, 6-7 illegal.
- A  input  WIDTH  operand A; latched at START.
- B  input  WIDTH  operand B; latched at START.
- BUSY  output  1  high from START acceptance until DONE.
- DONE  output  1  one-cycle pulse; RESULT and flags are valid from this cycle.
- RESULT  output  WIDTH  held until the next accepted START.
- COUT  output  1  carry out of the MSB for ADD/SUB; 0 for other ops.
- OVF  output  1  signed overflow for ADD/SUB; 0 for other ops.
- ZERO  output  1  RESULT == 0.
- ERR  output  1  illegal ALUOP; asserted with DONE.
- SA  output  1  slice input A bit.
- SB  output  1  slice input B bit.
- SCIN  output  1  slice carry in.
- SBINV  output  1  slice BInvert.
- SLESS  output  1  slice LESS; always 0.
- SOP  output  3  slice op: 000 AND, 010 OR, 011 XOR, 100 ADD.
- SREZ  input  1  slice result, combinational from the S* outputs.
- SCOUT  input  1  slice carry out.

Behaviour:
- States: IDLE, RUN, FIX, FIN.
- Reset (async, any state) forces:
  - state IDLE;
  - RESULT, COUT, OVF, ZERO, ERR, BUSY, DONE all 0;
  - slice drive all 0.
- IDLE:
  - On START=1 at edge t0: latch A, B and ALUOP; clear bit counter k; set BUSY.
  - Preload carry: 1 for SUB/SLT, else 0.
  - Legal ALUOP goes to RUN. Illegal ALUOP goes to FIN with RESULT=0, ERR=1.
- RUN, cycle between edges t0+k and t0+k+1, k = 0..WIDTH-1:
  - SA=A[k], SB=B[k], SCIN=carry.
  - SBINV=1 for SUB/SLT, else 0.
  - SOP per op; SUB and SLT use 100.
  - At edge t0+k+1: result <= {SREZ, result[WIDTH-1:1]} and carry <= SCOUT.
  - At k=WIDTH-1: capture COUT=SCOUT and OVF=carry^SCOUT (carry into MSB XOR carry out).
  - Then go to FIX if SLT, else FIN.
- FIX (SLT only, 1 cycle):
  - RESULT <= {0..0, SREZ_msb ^ OVF}, using the captured MSB of the difference.
  - COUT and OVF are then cleared to 0.
  - Next state FIN.
- FIN:
  - DONE=1 and BUSY=0 for exactly one cycle; ZERO computed from the final RESULT.
  - Next state IDLE.
  - A START sampled in this cycle is ignored.
- Latency from START edge t0 to DONE asserted:
  - WIDTH+1 edges (17) for non-SLT ops;
  - WIDTH+2 edges (18) for SLT;
  - 1 edge for illegal ALUOP.
- Boundary conditions:
  - START while BUSY is ignored.
  - A, B and ALUOP changes after t0 have no effect.
  - The slice drive outputs are 0 in every state except RUN.
  - Reset mid-RUN aborts the operation: no DONE; RESULT reads 0.
  - Back-to-back operation: the earliest next START is the cycle after FIN, when the block is back in IDLE.

Test Plan:
- ADD A=0x7FFF, B=0x0001 -> DONE at t0+17; RESULT=0x8000, COUT=0, OVF=1, ZERO=0; BUSY high 16 cycles.
- SUB A=0x0005, B=0x0007 -> RESULT=0xFFFE, COUT=0, OVF=0; check SBINV=1 and SCIN=1 at bit 0.
- SLT A=0xFFFD, B=0x0002 -> RESULT=0x0001, DONE at t0+18. SLT A=0x7FFF, B=0x8000 (overflow case) -> RESULT=0x0000.
- XOR A=0xA5A5, B=0xFFFF -> RESULT=0x5A5A, ZERO=0. AND A=0x0F0F, B=0xF0F0 -> RESULT=0x0000, ZERO=1, COUT=0, OVF=0.
- Illegal ALUOP=7 -> DONE and ERR at t0+1, RESULT=0. START re-pulsed during RUN -> ignored; exactly one DONE.
- RESETn low at k=8 of an ADD -> immediate IDLE, all outputs 0, no DONE. A new ADD 0x0001+0x0001 afterwards -> 0x0002.

Source files
------------

// File: rtl/alu_serial_seq.sv
// Bit-serial ALU sequencer: drives one external 1-bit ALU slice over WIDTH
// cycles, rippling the carry through a register and shifting the result in LSB first.
module alu_serial_seq #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             CLK,
    input  logic             RESETn,
    input  logic             START,
    input  logic [2:0]       ALUOP,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] RESULT,
    output logic             COUT,
    output logic             OVF,
    output logic             ZERO,
    output logic             ERR,
    output logic             SA,
    output logic             SB,
    output logic             SCIN,
    output logic             SBINV,
    output logic             SLESS,
    output logic [2:0]       SOP,
    input  logic             SREZ,
    input  logic             SCOUT
);

    localparam int unsigned KW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX,
        FIN
    } state_t;

    typedef enum logic [2:0] {
        OP_AND  = 3'd0,
        OP_OR   = 3'd1,
        OP_XOR  = 3'd2,
        OP_ADD  = 3'd3,
        OP_SUB  = 3'd4,
        OP_SLT  = 3'd5,
        OP_ILL6 = 3'd6,
        OP_ILL7 = 3'd7
    } alu_op_t;

    localparam logic [2:0] SOP_AND = 3'b000;
    localparam logic [2:0] SOP_OR  = 3'b010;
    localparam logic [2:0] SOP_XOR = 3'b011;
    localparam logic [2:0] SOP_ADD = 3'b100;

    state_t           state_q,  state_d;
    alu_op_t          op_q,     op_d;
    logic [WIDTH-1:0] a_q,      a_d;
    logic [WIDTH-1:0] b_q,      b_d;
    logic [KW-1:0]    k_q,      k_d;
    logic             carry_q,  carry_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             cout_q,   cout_d;
    logic             ovf_q,    ovf_d;
    logic             zero_q,   zero_d;
    logic             err_q,    err_d;
    logic             busy_q,   busy_d;
    logic             done_q,   done_d;

    alu_op_t req_op;

    function automatic logic op_legal(input alu_op_t op);
        return (op != OP_ILL6) && (op != OP_ILL7);
    endfunction

    function automatic logic op_arith(input alu_op_t op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_SLT);
    endfunction

    function automatic logic op_binv(input alu_op_t op);
        return (op == OP_SUB) || (op == OP_SLT);
    endfunction

    function automatic logic [2:0] slice_op(input alu_op_t op);
        logic [2:0] s;
        case (op)
            OP_AND:  s = SOP_AND;
            OP_OR:   s = SOP_OR;
            OP_XOR:  s = SOP_XOR;
            default: s = SOP_ADD;
        endcase
        return s;
    endfunction

    assign req_op = alu_op_t'(ALUOP);

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        k_d      = k_q;
        carry_d  = carry_q;
        result_d = result_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        zero_d   = zero_q;
        err_d    = err_q;
        busy_d   = busy_q;
        done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (START) begin
                    a_d      = A;
                    b_d      = B;
                    op_d     = req_op;
                    k_d      = '0;
                    carry_d  = op_binv(req_op);
                    result_d = '0;
                    cout_d   = 1'b0;
                    ovf_d    = 1'b0;
                    zero_d   = 1'b0;
                    err_d    = 1'b0;
                    if (op_legal(req_op)) begin
                        state_d = RUN;
                        busy_d  = 1'b1;
                    end else begin
                        state_d = FIN;
                        busy_d  = 1'b0;
                    end
                end
            end

            RUN: begin
                result_d = {SREZ, result_q[WIDTH-1:1]};
                carry_d  = SCOUT;
                k_d      = k_q + KW'(1);
                if (k_q == K_LAST) begin
                    // carry_q here is the carry into the MSB slice
                    cout_d  = op_arith(op_q) & SCOUT;
                    ovf_d   = op_arith(op_q) & (carry_q ^ SCOUT);
                    if (op_q == OP_SLT) begin
                        state_d = FIX;
                    end else begin
                        state_d = FIN;
                        busy_d  = 1'b0;
                    end
                end
            end

            FIX: begin
                result_d    = '0;
                result_d[0] = result_q[WIDTH-1] ^ ovf_q;
                cout_d      = 1'b0;
                ovf_d       = 1'b0;
                busy_d      = 1'b0;
                state_d     = FIN;
            end

            FIN: begin
                done_d  = 1'b1;
                zero_d  = (result_q == '0);
                err_d   = ~op_legal(op_q);
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state_q  <= IDLE;
            op_q     <= OP_AND;
            a_q      <= '0;
            b_q      <= '0;
            k_q      <= '0;
            carry_q  <= 1'b0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            k_q      <= k_d;
            carry_q  <= carry_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    // Slice drive is purely a decode of the current bit; quiet outside RUN
    always_comb begin
        SA    = 1'b0;
        SB    = 1'b0;
        SCIN  = 1'b0;
        SBINV = 1'b0;
        SOP   = 3'b000;
        if (state_q == RUN) begin
            SA    = a_q[k_q];
            SB    = b_q[k_q];
            SCIN  = carry_q;
            SBINV = op_binv(op_q);
            SOP   = slice_op(op_q);
        end
    end

    assign SLESS  = 1'b0;
    assign BUSY   = busy_q;
    assign DONE   = done_q;
    assign RESULT = result_q;
    assign COUT   = cout_q;
    assign OVF    = ovf_q;
    assign ZERO   = zero_q;
    assign ERR    = err_q;

endmodule

// File: tb/tb_alu_serial_seq.sv
// Scoreboard bench for alu_serial_seq with a behavioural 1-bit slice and an
// arithmetic reference model of the whole WIDTH-bit operation.
module tb_alu_serial_seq;

    localparam int W = 16;

    logic         CLK = 1'b0;
    logic         RESETn = 1'b0;
    logic         START = 1'b0;
    logic [2:0]   ALUOP = '0;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic         BUSY, DONE, COUT, OVF, ZERO, ERR;
    logic [W-1:0] RESULT;
    logic         SA, SB, SCIN, SBINV, SLESS;
    logic [2:0]   SOP;
    logic         SREZ, SCOUT;

    alu_serial_seq #(.WIDTH(W)) dut (
        .CLK(CLK), .RESETn(RESETn), .START(START), .ALUOP(ALUOP), .A(A), .B(B),
        .BUSY(BUSY), .DONE(DONE), .RESULT(RESULT), .COUT(COUT), .OVF(OVF),
        .ZERO(ZERO), .ERR(ERR), .SA(SA), .SB(SB), .SCIN(SCIN), .SBINV(SBINV),
        .SLESS(SLESS), .SOP(SOP), .SREZ(SREZ), .SCOUT(SCOUT)
    );

    always #5 CLK = ~CLK;

    // External 1-bit ALU slice
    logic bb;
    assign bb    = SB ^ SBINV;
    assign SCOUT = (SA & bb) | (SA & SCIN) | (bb & SCIN);
    assign SREZ  = (SOP == 3'b000) ? (SA & bb) :
                   (SOP == 3'b010) ? (SA | bb) :
                   (SOP == 3'b011) ? (SA ^ bb) :
                   (SOP == 3'b100) ? (SA ^ bb ^ SCIN) : 1'b0;

    typedef struct {
        logic [W-1:0] res;
        logic         cout;
        logic         ovf;
        logic         zero;
        logic         err;
        int           done_cyc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    always @(posedge CLK) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        logic [W:0] s;
        e.res = '0; e.cout = 0; e.ovf = 0; e.err = 0; e.done_cyc = 0;
        case (op)
            3'd0: e.res = a & b;
            3'd1: e.res = a | b;
            3'd2: e.res = a ^ b;
            3'd3: begin
                s = {1'b0, a} + {1'b0, b};
                e.res = s[W-1:0]; e.cout = s[W];
                e.ovf = (a[W-1] == b[W-1]) && (e.res[W-1] != a[W-1]);
            end
            3'd4: begin
                s = {1'b0, a} + {1'b0, ~b} + 17'd1;
                e.res = s[W-1:0]; e.cout = s[W];
                e.ovf = (a[W-1] != b[W-1]) && (e.res[W-1] != a[W-1]);
            end
            3'd5: e.res = ($signed(a) < $signed(b)) ? 16'd1 : 16'd0;
            default: e.err = 1;
        endcase
        e.zero = (e.res == '0);
        return e;
    endfunction

    function automatic logic [2:0] exp_sop(input logic [2:0] op);
        case (op)
            3'd0: return 3'b000;
            3'd1: return 3'b010;
            3'd2: return 3'b011;
            default: return 3'b100;
        endcase
    endfunction

    // Monitor: pops one expectation per DONE pulse; slice must be quiet while idle
    always @(negedge CLK) begin
        exp_t e;
        if (!BUSY)
            chk("slice_idle", {24'd0, SA, SB, SCIN, SBINV, SLESS, SOP}, 32'd0);
        if (DONE) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("done_cycle", cyc, e.done_cyc);
                chk("result", RESULT, e.res);
                chk("cout", COUT, e.cout);
                chk("ovf", OVF, e.ovf);
                chk("zero", ZERO, e.zero);
                chk("err", ERR, e.err);
                chk("busy_at_done", BUSY, 0);
            end
        end
    end

    // Called at a negedge; returns at the negedge where DONE is seen
    task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        int   t0c, busy_n, bitk, exp_busy;
        bit   done_seen, legal, inv;
        e     = model(op, a, b);
        legal = (op <= 3'd5);
        inv   = (op == 3'd4) || (op == 3'd5);
        exp_busy = !legal ? 0 : (op == 3'd5) ? W + 1 : W;
        START = 1; ALUOP = op; A = a; B = b;
        @(posedge CLK);
        #1;
        t0c = cyc;
        e.done_cyc = t0c + (!legal ? 1 : (op == 3'd5) ? W + 2 : W + 1);
        sb.push_back(e);
        START = 0;
        A = W'($urandom); B = W'($urandom); ALUOP = 3'($urandom);
        busy_n = 0; bitk = 0; done_seen = 0;
        for (int i = 0; i < 40 && !done_seen; i++) begin
            @(negedge CLK);
            if (DONE) begin
                done_seen = 1;
            end else if (BUSY) begin
                if (bitk < W) begin
                    chk("slice_a", SA, a[bitk]);
                    chk("slice_b", SB, b[bitk]);
                    chk("slice_binv", SBINV, inv);
                    chk("slice_op", SOP, exp_sop(op));
                    if (bitk == 0) chk("slice_cin0", SCIN, inv);
                end
                bitk++; busy_n++;
                START = 1'($urandom);
                A = W'($urandom); B = W'($urandom); ALUOP = 3'($urandom);
            end else begin
                START = 1;
                A = W'($urandom); B = W'($urandom); ALUOP = 3'($urandom);
            end
        end
        START = 0;
        chk("done_seen", done_seen, 1);
        chk("busy_cycles", busy_n, exp_busy);
    endtask

    function automatic logic [W-1:0] pick_operand();
        case ($urandom_range(0, 7))
            0: return 16'h0000;
            1: return 16'hFFFF;
            2: return 16'h7FFF;
            3: return 16'h8000;
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        repeat (3) @(negedge CLK);
        chk("reset_outs", {RESULT, BUSY, DONE, COUT, OVF, ZERO, ERR}, 32'd0);
        RESETn = 1;

        run_op(3'd3, 16'h7FFF, 16'h0001);
        run_op(3'd4, 16'h0005, 16'h0007);
        run_op(3'd5, 16'hFFFD, 16'h0002);
        run_op(3'd5, 16'h7FFF, 16'h8000);
        run_op(3'd2, 16'hA5A5, 16'hFFFF);
        run_op(3'd0, 16'h0F0F, 16'hF0F0);
        run_op(3'd7, 16'h1234, 16'h5678);
        run_op(3'd6, 16'h0000, 16'h0000);
        run_op(3'd4, 16'h8000, 16'h0001);

        for (int n = 0; n < 60; n++) begin
            logic [2:0] op;
            op = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(6, 7)) : 3'($urandom_range(0, 5));
            run_op(op, pick_operand(), pick_operand());
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge CLK);
        end

        // Abort an ADD at bit 8 with an asynchronous reset
        START = 1; ALUOP = 3'd3; A = 16'h1234; B = 16'h4321;
        @(posedge CLK);
        #1;
        START = 0;
        repeat (9) @(negedge CLK);
        RESETn = 0;
        #1;
        chk("abort_outs", {RESULT, BUSY, DONE, COUT, OVF, ZERO, ERR}, 32'd0);
        chk("abort_slice", {SA, SB, SCIN, SBINV, SLESS, SOP}, 32'd0);
        @(negedge CLK);
        RESETn = 1;
        seen = 0;
        repeat (20) begin
            @(negedge CLK);
            if (DONE) seen = 1;
        end
        chk("abort_no_done", seen, 0);
        chk("abort_result", RESULT, 16'h0000);

        run_op(3'd3, 16'h0001, 16'h0001);
        repeat (3) @(negedge CLK);
        chk("scoreboard_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
